// File: rtl/variable_shift_1bit_serial.sv
// variable_shift_1bit_serial
//   Purpose : serial barrel-shift replacement; an operand captured on data_start
//             moves one bit position per CLK until its shift count is exhausted,
//             then the result is published on a held output register.
//   Latency : load on edge L, shifts on L+1..L+n, shifted_a/done update on L+n+1.
//   Backpressure: none; a data_start during an unfinished shift abandons it and
//             restarts with the new operand (no done, shifted_a keeps old value).
//
// Build option: define SHIFT_RIGHT_EN to shift right (logical) instead of left.
//
// Ports:
//   CLK         - system clock, rising edge
//   RST         - asynchronous active-low reset
//   a           - operand, sampled when data_start=1
//   shift_width - unsigned shift amount, sampled with a
//   data_start  - one-cycle load strobe
//   shifted_a   - registered result, held until the next completion
//   done        - one-cycle pulse in the cycle shifted_a was just updated

module variable_shift_1bit_serial #(
  parameter int WIDTH    = 8,
  parameter int SW_WIDTH = 3
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic [WIDTH-1:0]    a,
  input  logic [SW_WIDTH-1:0] shift_width,
  input  logic                data_start,
  output logic [WIDTH-1:0]    shifted_a,
  output logic                done
);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_e;

  state_e              state_q, state_d;
  logic [WIDTH-1:0]    work_q, work_d;
  logic [SW_WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0]    result_q, result_d;
  logic                done_q, done_d;

  // One-position step of the working register; the build option selects direction.
  logic [WIDTH-1:0]    work_step;
`ifdef SHIFT_RIGHT_EN
  assign work_step = work_q >> 1;
`else
  assign work_step = work_q << 1;
`endif

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q  <= IDLE;
      work_q   <= '0;
      count_q  <= '0;
      result_q <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      work_q   <= work_d;
      count_q  <= count_d;
      result_q <= result_d;
      done_q   <= done_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    work_d   = work_q;
    count_d  = count_q;
    result_d = result_q;
    done_d   = 1'b0;

    case (state_q)
      IDLE: begin
        if (data_start) begin
          work_d  = a;
          count_d = shift_width;
          state_d = SHIFT;
        end
      end

      SHIFT: begin
        if (count_q == '0) begin
          // Completion; a coincident data_start (periodic operand after a
          // maximum-length shift) is honoured on the same edge.
          result_d = work_q;
          done_d   = 1'b1;
          if (data_start) begin
            work_d  = a;
            count_d = shift_width;
            state_d = SHIFT;
          end else begin
            state_d = IDLE;
          end
        end else if (data_start) begin
          // Restart: current operation is dropped without publishing.
          work_d  = a;
          count_d = shift_width;
        end else begin
          work_d  = work_step;
          count_d = count_q - SW_WIDTH'(1);
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign shifted_a = result_q;
  assign done      = done_q;

endmodule

// File: tb/tb_variable_shift_1bit_serial.sv
// Directed bench for variable_shift_1bit_serial: a table of single operations,
// hand-written multi-cycle sequences (back-to-back, restart, held strobe,
// reset mid-shift) and a counter-driven sweep with one operand every 8 CLK.

module tb_variable_shift_1bit_serial;

`ifdef SHIFT_RIGHT_EN
  localparam bit RIGHT = 1'b1;
`else
  localparam bit RIGHT = 1'b0;
`endif

  logic       CLK = 1'b0;
  logic       RST;
  logic [7:0] a;
  logic [2:0] shift_width;
  logic       data_start;
  logic [7:0] shifted_a;
  logic       done;

  int checks = 0;
  int errors = 0;

  variable_shift_1bit_serial #(.WIDTH(8), .SW_WIDTH(3)) dut (
    .CLK        (CLK),
    .RST        (RST),
    .a          (a),
    .shift_width(shift_width),
    .data_start (data_start),
    .shifted_a  (shifted_a),
    .done       (done)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [7:0] a;
    int         n;
    logic [7:0] exp_l;
    logic [7:0] exp_r;
  } vec_t;

  vec_t vecs [6];

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Present inputs for the coming edge, take the edge, settle 1 time unit.
  task automatic step(input logic start, input logic [7:0] av, input logic [2:0] nv);
    data_start  = start;
    a           = av;
    shift_width = nv;
    @(posedge CLK);
    #1;
    data_start = 1'b0;
  endtask

  function automatic logic [7:0] pick(input logic [7:0] l, input logic [7:0] r);
    return RIGHT ? r : l;
  endfunction

  function automatic logic [7:0] model(input logic [7:0] av, input int n);
    logic [7:0] r;
    r = RIGHT ? (av >> n) : (av << n);
    return r;
  endfunction

  logic [7:0] held;
  int         edge_no;
  int         exp_edge;
  logic [7:0] exp_val;
  logic [2:0] nv;

  initial begin
    vecs[0] = '{8'h2D, 3, 8'h68, 8'h05};
    vecs[1] = '{8'hFF, 0, 8'hFF, 8'hFF};
    vecs[2] = '{8'h81, 7, 8'h80, 8'h01};
    vecs[3] = '{8'h01, 1, 8'h02, 8'h00};
    vecs[4] = '{8'hF0, 4, 8'h00, 8'h0F};
    vecs[5] = '{8'hA5, 2, 8'h94, 8'h29};

    RST = 1'b0; a = '0; shift_width = '0; data_start = 1'b0;
    #1;
    chk("reset shifted_a", shifted_a, 8'h00);
    chk("reset done", {7'd0, done}, 8'h00);
    @(posedge CLK); #1;
    @(posedge CLK); #1;
    RST = 1'b1;
    step(0, 8'h00, 3'd0);
    chk("idle after reset done", {7'd0, done}, 8'h00);

    // Table of single operations.
    for (int i = 0; i < 6; i++) begin
      step(1, vecs[i].a, 3'(vecs[i].n));
      chk($sformatf("v%0d load edge done", i), {7'd0, done}, 8'h00);
      for (int j = 1; j <= vecs[i].n; j++) begin
        step(0, 8'h00, 3'd0);
        chk($sformatf("v%0d shift%0d done", i, j), {7'd0, done}, 8'h00);
      end
      step(0, 8'h00, 3'd0);
      chk($sformatf("v%0d done", i), {7'd0, done}, 8'h01);
      chk($sformatf("v%0d result", i), shifted_a, pick(vecs[i].exp_l, vecs[i].exp_r));
      step(0, 8'h00, 3'd0);
      chk($sformatf("v%0d done drop", i), {7'd0, done}, 8'h00);
      chk($sformatf("v%0d result held", i), shifted_a, pick(vecs[i].exp_l, vecs[i].exp_r));
    end

    // Back-to-back: n=7 completes on the same edge the next operand loads.
    step(1, 8'h81, 3'd7);
    for (int j = 1; j <= 7; j++) step(0, 8'h00, 3'd0);
    chk("b2b pre-done", {7'd0, done}, 8'h00);
    step(1, 8'h82, 3'd0);
    chk("b2b first done", {7'd0, done}, 8'h01);
    chk("b2b first result", shifted_a, pick(8'h80, 8'h01));
    step(0, 8'h00, 3'd0);
    chk("b2b second done", {7'd0, done}, 8'h01);
    chk("b2b second result", shifted_a, 8'h82);
    step(0, 8'h00, 3'd0);
    chk("b2b idle done", {7'd0, done}, 8'h00);

    // Restart: first operand abandoned, no done, result held.
    held = shifted_a;
    step(1, 8'h11, 3'd6);
    step(0, 8'h00, 3'd0);
    step(1, 8'h03, 3'd2);
    for (int j = 0; j < 2; j++) begin
      step(0, 8'h00, 3'd0);
      chk($sformatf("restart wait%0d done", j), {7'd0, done}, 8'h00);
      chk($sformatf("restart wait%0d held", j), shifted_a, held);
    end
    step(0, 8'h00, 3'd0);
    chk("restart done", {7'd0, done}, 8'h01);
    chk("restart result", shifted_a, pick(8'h0C, 8'h00));

    // data_start held high for three edges: only the last load completes.
    step(1, 8'h01, 3'd1);
    step(1, 8'h02, 3'd1);
    step(1, 8'h04, 3'd1);
    chk("held strobe done0", {7'd0, done}, 8'h00);
    step(0, 8'h00, 3'd0);
    chk("held strobe done1", {7'd0, done}, 8'h00);
    step(0, 8'h00, 3'd0);
    chk("held strobe done", {7'd0, done}, 8'h01);
    chk("held strobe result", shifted_a, pick(8'h08, 8'h02));

    // Reset mid-shift: immediate clear, then silence until next data_start.
    step(1, 8'hAA, 3'd5);
    step(0, 8'h00, 3'd0);
    step(0, 8'h00, 3'd0);
    RST = 1'b0;
    #1;
    chk("midreset shifted_a", shifted_a, 8'h00);
    chk("midreset done", {7'd0, done}, 8'h00);
    @(posedge CLK); #1;
    RST = 1'b1;
    for (int j = 0; j < 8; j++) begin
      step(0, 8'h00, 3'd0);
      chk($sformatf("post-reset quiet%0d", j), {7'd0, done}, 8'h00);
    end
    step(1, 8'h2D, 3'd3);
    for (int j = 0; j < 3; j++) step(0, 8'h00, 3'd0);
    step(0, 8'h00, 3'd0);
    chk("post-reset op done", {7'd0, done}, 8'h01);
    chk("post-reset op result", shifted_a, pick(8'h68, 8'h05));

    // Sweep: one operand every 8 CLK, a counts 0..255, n varies with a.
    edge_no  = 0;
    exp_edge = -1;
    exp_val  = '0;
    for (int k = 0; k < 264; k++) begin
      nv = 3'(k) ^ 3'(k >> 3);
      for (int c = 0; c < 8; c++) begin
        step((c == 0) && (k < 256), 8'(k), nv);
        edge_no++;
        if (edge_no == exp_edge) begin
          chk($sformatf("sweep done a=%0d", k - ((c == 0) ? 1 : 0)), {7'd0, done}, 8'h01);
          chk("sweep result", shifted_a, exp_val);
        end else begin
          chk("sweep quiet", {7'd0, done}, 8'h00);
        end
        if (c == 0 && k < 256) begin
          exp_edge = edge_no + int'(nv) + 1;
          exp_val  = model(8'(k), int'(nv));
        end
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
